// File: rtl/dmem_bus_bridge.sv
// MEM-stage to request/response bus bridge: one outstanding access, pipeline
// stall while busy, and a sticky timeout fault that records the first failing address.
module dmem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_out,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [3:0]  byte_enable,
    output logic [31:0] mem_data_in,
    output logic        stall,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata,
    output logic        fault,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] cap_addr;
    logic [7:0]  tmo_cnt;
    logic        mem_req, busy, rsp_done, tmo_hit;

    assign mem_req  = mem_read_en | mem_write_en;
    assign busy     = (state == REQ) || (state == WAIT_RSP);
    assign rsp_done = (state == WAIT_RSP) && bus_rsp_valid;
    // A response on the expiring edge still counts as a normal completion.
    assign tmo_hit  = busy && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) && !rsp_done;
    assign bus_addr = {cap_addr[31:2], 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (mem_req) state_nxt = REQ;
            REQ:      if (tmo_hit) state_nxt = DONE;
                      else if (bus_req_ready) state_nxt = WAIT_RSP;
            WAIT_RSP: if (rsp_done || tmo_hit) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall         = 1'b0;
        bus_req_valid = 1'b0;
        case (state)
            IDLE:     stall = mem_req;
            REQ:      begin stall = 1'b1; bus_req_valid = 1'b1; end
            WAIT_RSP: stall = 1'b1;
            default:  stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_addr    <= '0;
            bus_wdata   <= '0;
            bus_be      <= '0;
            bus_we      <= 1'b0;
            tmo_cnt     <= '0;
            mem_data_in <= '0;
            fault       <= 1'b0;
            fault_addr  <= '0;
        end else begin
            // Payload is only captured in IDLE, so it is frozen for the whole access.
            if (state == IDLE && mem_req) begin
                cap_addr  <= mem_addr;
                bus_wdata <= mem_data_out;
                bus_be    <= byte_enable;
                bus_we    <= mem_write_en;
                tmo_cnt   <= '0;
            end else if (busy) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            if (rsp_done)
                mem_data_in <= bus_we ? 32'h0 : bus_rdata;
            else if (tmo_hit)
                mem_data_in <= 32'h0;

            if (tmo_hit) begin
                fault <= 1'b1;
                if (!fault) fault_addr <= cap_addr;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge: directed and randomized accesses against a
// transaction-level model of latency, returned data and fault tracking.
module tb_dmem_bus_bridge;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_addr = '0, mem_data_out = '0;
    logic        mem_read_en = 1'b0, mem_write_en = 1'b0;
    logic [3:0]  byte_enable = '0;
    logic [31:0] mem_data_in;
    logic        stall, bus_req_valid, bus_we;
    logic        bus_req_ready = 1'b0;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        fault;
    logic [31:0] fault_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic        ref_fault = 1'b0;
    logic [31:0] ref_faddr = '0;
    logic [31:0] ref_data  = '0;

    dmem_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .byte_enable(byte_enable), .mem_data_in(mem_data_in), .stall(stall),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata),
        .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Pipeline holds the request until stall drops; the bus agent raises ready
    // after rdly request cycles and responds after sdly wait cycles.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic rd, input logic wr,
                           input int rdly, input int sdly, input logic [31:0] rdata);
        int  k, exp_stall, n_stall, seen, wseen, guard;
        bit  to, accepted, ended;
        k         = rdly + sdly + 2;
        to        = (k > T);
        exp_stall = 1 + (to ? T : k);
        if (to) begin
            ref_data = 32'h0;
            if (!ref_fault) begin ref_fault = 1'b1; ref_faddr = addr; end
        end else begin
            ref_data = wr ? 32'h0 : rdata;
        end

        mem_addr = addr; mem_data_out = wdata; byte_enable = be;
        mem_read_en = rd; mem_write_en = wr;
        bus_rdata = rdata;
        #1;
        n_stall = 0; seen = 0; wseen = 0; guard = 0; accepted = 0; ended = 0;
        while (!ended && guard < 300) begin
            guard++;
            if (!stall) begin
                ended = 1;
            end else begin
                n_stall++;
                if (bus_req_valid) begin
                    chk({tag, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
                    chk({tag, " bus_we"}, {31'b0, bus_we}, {31'b0, wr});
                    chk({tag, " bus_wdata"}, bus_wdata, wdata);
                    chk({tag, " bus_be"}, {28'b0, bus_be}, {28'b0, be});
                    bus_req_ready = (seen >= rdly);
                    if (bus_req_ready) accepted = 1;
                    seen++;
                    bus_rsp_valid = 1'b0;
                end else if (accepted) begin
                    bus_req_ready = 1'b0;
                    bus_rsp_valid = (wseen >= sdly);
                    wseen++;
                end else begin
                    bus_req_ready = 1'b0;
                    bus_rsp_valid = 1'b0;
                end
                step();
            end
        end
        chk({tag, " completed"}, {31'b0, ended}, 32'd1);
        chk({tag, " stall_cycles"}, n_stall, exp_stall);
        chk({tag, " mem_data_in"}, mem_data_in, ref_data);
        chk({tag, " fault"}, {31'b0, fault}, {31'b0, ref_fault});
        chk({tag, " fault_addr"}, fault_addr, ref_faddr);

        mem_read_en = 1'b0; mem_write_en = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        step();
        chk({tag, " idle_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, " idle_valid"}, {31'b0, bus_req_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d, r;
        logic [3:0]  b;
        logic        rd, wr;

        repeat (3) step();
        chk("rst stall", {31'b0, stall}, 32'd0);
        chk("rst valid", {31'b0, bus_req_valid}, 32'd0);
        chk("rst data", mem_data_in, 32'd0);
        chk("rst fault", {31'b0, fault}, 32'd0);
        chk("rst faddr", fault_addr, 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        reset = 1'b1;
        step();

        run_txn("word_rd", 32'h0000_1006, 32'h1234_5678, 4'b1111, 1, 0, 0, 0, 32'hDEAD_BEEF);
        run_txn("byte_wr", 32'h0000_2003, 32'hAB00_0000, 4'b1000, 0, 1, 2, 0, 32'h5555_AAAA);
        run_txn("rd_wr", 32'h0000_2100, 32'hCAFE_F00D, 4'b0011, 1, 1, 0, 1, 32'h7777_7777);
        run_txn("tmo1", 32'h0000_3000, 32'h0, 4'b1111, 1, 0, 100, 0, 32'h1111_1111);
        run_txn("tmo2", 32'h0000_4000, 32'h0, 4'b1111, 1, 0, 100, 0, 32'h2222_2222);
        run_txn("edge_cmpl", 32'h0000_5004, 32'h0, 4'b1111, 1, 0, 7, 7, 32'h3333_3333);

        for (int i = 0; i < 24; i++) begin
            a  = $urandom; d = $urandom; r = $urandom; b = 4'($urandom);
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            run_txn("rand", a, d, b, rd, wr, $urandom_range(0, 9), $urandom_range(0, 9), r);
        end

        bus_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_rdata = $urandom;
            step();
            chk("stray data", mem_data_in, ref_data);
            chk("stray stall", {31'b0, stall}, 32'd0);
            chk("stray valid", {31'b0, bus_req_valid}, 32'd0);
        end
        bus_rsp_valid = 1'b0;

        mem_addr = 32'h0000_6008; mem_data_out = 32'h9999_0000; byte_enable = 4'b1111;
        mem_read_en = 1'b1; bus_req_ready = 1'b1;
        step();
        step();
        chk("mid wait stall", {31'b0, stall}, 32'd1);
        chk("mid wait valid", {31'b0, bus_req_valid}, 32'd0);
        reset = 1'b0; mem_read_en = 1'b0; bus_req_ready = 1'b0;
        #1;
        chk("arst stall", {31'b0, stall}, 32'd0);
        chk("arst valid", {31'b0, bus_req_valid}, 32'd0);
        chk("arst data", mem_data_in, 32'd0);
        chk("arst fault", {31'b0, fault}, 32'd0);
        chk("arst faddr", fault_addr, 32'd0);
        chk("arst bus_addr", bus_addr, 32'd0);
        chk("arst bus_wdata", bus_wdata, 32'd0);
        chk("arst bus_be_we", {27'b0, bus_we, bus_be}, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("post rst valid", {31'b0, bus_req_valid}, 32'd0);
        chk("post rst stall", {31'b0, stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_bus_bridge.md
DMEM_BUS_BRIDGE -- requirements
Module: dmem_bus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum cycles a transaction may spend in REQ plus WAIT_RSP before it is aborted (legal range 2..255).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 mem_addr  input  32  SHALL carry the byte address from the MEM-stage interface.
REQ-005 mem_data_out  input  32  SHALL carry the write data, lane-placed by upstream.
REQ-006 mem_read_en  input  1  SHALL be the read request level.
REQ-007 mem_write_en  input  1  SHALL be the write request level.
REQ-008 byte_enable  input  4  SHALL give the active byte lanes.
REQ-009 mem_data_in  output  32  SHALL return the raw read word to the MEM-stage interface.
REQ-010 stall  output  1  SHALL freeze the pipeline while an access is unfinished.
REQ-011 bus_req_valid  output  1  SHALL be the bus request valid signal.
REQ-012 bus_req_ready  input  1  SHALL be the bus request ready signal.
REQ-013 bus_we, bus_addr[31:0], bus_wdata[31:0], bus_be[3:0]  outputs  SHALL carry the request payload.
REQ-014 bus_rsp_valid  input  1  and bus_rdata  input  32  SHALL carry the bus response.
REQ-015 fault  output  1  SHALL be a sticky timeout flag; fault_addr  output  32  SHALL hold the address of the first timed-out access.

Function
REQ-016 The FSM SHALL have four states: IDLE, REQ, WAIT_RSP and DONE; at most one transaction SHALL be outstanding.
REQ-017 IDLE: when mem_read_en or mem_write_en is high, the block SHALL capture addr, wdata, be and we (we = mem_write_en) into registers and move to REQ on the next edge.
REQ-018 When read and write are both high, the access SHALL be treated as a write.
REQ-019 bus_addr SHALL be {captured_addr[31:2], 2'b00}; bus_wdata, bus_be and bus_we SHALL be the captured values.
REQ-020 All bus_* payload outputs SHALL remain stable from entry to REQ until the handshake completes.
REQ-021 REQ: bus_req_valid SHALL be 1; on an edge where bus_req_ready=1, the FSM SHALL move to WAIT_RSP; bus_req_valid SHALL be 0 in every other state.
REQ-022 WAIT_RSP: on an edge where bus_rsp_valid=1, the block SHALL register bus_rdata (reads) or 32'h0 (writes) into mem_data_in and move to DONE.
REQ-023 bus_rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-024 DONE SHALL last exactly one cycle, then return to IDLE; no new request SHALL be sampled in DONE.
REQ-025 stall SHALL be combinational: 1 in IDLE when a request is present, 1 in REQ and WAIT_RSP, and 0 in DONE and in idle IDLE.
REQ-026 mem_data_in SHALL hold its last registered value until the next completion.
REQ-027 Minimum latency SHALL be 3 stall cycles (IDLE, REQ with ready=1, WAIT_RSP with rsp_valid=1), with stall=0 in the fourth cycle (DONE).
REQ-028 An 8-bit timeout counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT_RSP.
REQ-029 When the timeout counter equals TIMEOUT_CYCLES-1 and the transaction has not completed, the block SHALL do all of the following on that edge: set fault, load fault_addr with the captured address only if fault was 0, set mem_data_in to 0, and move to DONE.
REQ-030 A completion and a timeout on the same edge SHALL be resolved as a normal completion.
REQ-031 fault SHALL be cleared only by reset.

Reset
REQ-032 When reset is low, the block SHALL asynchronously force the state to IDLE and clear every output and internal register (mem_data_in, bus_* payload, fault, fault_addr, counter) to 0; stall SHALL then follow REQ-025.
REQ-033 A reset asserted mid-transaction SHALL abandon the transaction and leave no bus request pending.

Verification
REQ-034 Word read: addr 0x0000_1006, be 4'b1111, ready=1, rsp on the first WAIT_RSP cycle with rdata 0xDEADBEEF -> bus_addr 0x0000_1004, stall high for 3 cycles, then mem_data_in=0xDEADBEEF with stall=0.
REQ-035 Byte write: addr 0x0000_2003, data 0xAB000000, be 4'b1000, ready delayed 2 cycles -> bus_we=1 and payload stable across the wait, mem_data_in=0, stall high for 5 cycles.
REQ-036 Read and write both high -> bus_we=1.
REQ-037 Timeout: ready held 0, TIMEOUT_CYCLES=16, addr 0x0000_3000 -> DONE after 16 REQ cycles; fault=1, fault_addr=0x0000_3000, mem_data_in=0.
REQ-038 A second timeout at 0x0000_4000 -> fault_addr stays 0x0000_3000.
REQ-039 Reset pulled low in WAIT_RSP -> state IDLE, all outputs 0, bus_req_valid 0.
REQ-040 A stray bus_rsp_valid while in IDLE -> no state change and mem_data_in unchanged.
